// File: rtl/lcd_char_ctrl.sv
// HD44780-style 16x2 character LCD sequencer: power-on init, then
// UART bytes -> timed bus writes with wrap, newline and clear handling.
module lcd_char_ctrl #(
  parameter int CLK_HZ  = 27_000_000,
  parameter int INIT_US = 15000,
  parameter int CMD_US  = 40,
  parameter int CLR_US  = 1640,
  parameter int EN_CYC  = 16,
  parameter int COLS    = 16
) (
  input  logic       CLK_I,
  input  logic       RST_N_I,
  input  logic [7:0] DATA_I,
  input  logic       VALID_I,
  output logic       READY_O,
  output logic       LCD_RW_O,
  output logic       LCD_RS_O,
  output logic       LCD_EN_O,
  output logic [7:0] LCD_DATA_O
);

  localparam int MHZ      = CLK_HZ / 1_000_000;
  localparam int INIT_CYC = MHZ * INIT_US;
  localparam int CMD_CYC  = MHZ * CMD_US;
  localparam int CLR_CYC  = MHZ * CLR_US;
  localparam int MAX_A    = INIT_CYC > CLR_CYC ? INIT_CYC : CLR_CYC;
  localparam int MAX_B    = CMD_CYC > EN_CYC ? CMD_CYC : EN_CYC;
  localparam int MAX_C    = MAX_A > MAX_B ? MAX_A : MAX_B;
  localparam int CW       = $clog2(MAX_C + 1);
  localparam int LW       = $clog2(COLS + 1);

  localparam logic [CW-1:0] INIT_C  = CW'(INIT_CYC);
  localparam logic [CW-1:0] CMD_C   = CW'(CMD_CYC);
  localparam logic [CW-1:0] CLR_C   = CW'(CLR_CYC);
  localparam logic [CW-1:0] EN_LAST = CW'(EN_CYC - 1);
  localparam logic [LW-1:0] COLS_C  = LW'(COLS);

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    SETUP,
    PULSE,
    HOLD,
    WAIT,
    IDLE,
    ADDR
  } state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [CW-1:0]   r_wlen, w_wlen;
  logic [1:0]      r_idx, w_idx;
  logic            r_boot, w_boot;
  logic [LW-1:0]   r_col, w_col;
  logic            r_line, w_line;
  logic            r_pend, w_pend;
  logic [7:0]      r_byte, w_byte;
  logic            r_rs, w_rs;
  logic [7:0]      r_data, w_data;
  logic            r_en, w_en;
  logic [7:0]      w_addr;
  logic            w_ff;
  logic            w_nl;
  logic            w_pr;

  function automatic logic [7:0] f_init(
    input logic [1:0] idx
  );
    logic [7:0] c;
    case (idx)
      2'd0:    c = 8'h38;
      2'd1:    c = 8'h0C;
      2'd2:    c = 8'h01;
      default: c = 8'h06;
    endcase
    return c;
  endfunction

  assign w_addr = r_line ? 8'h80 : 8'hC0;
  assign w_ff   = (r_byte == 8'h0C);
  assign w_nl   = (r_byte == 8'h0A);
  assign w_pr   = (r_byte >= 8'h20) && (r_byte <= 8'h7E);

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt + CW'(1);
    w_wlen  = r_wlen;
    w_idx   = r_idx;
    w_boot  = r_boot;
    w_col   = r_col;
    w_line  = r_line;
    w_pend  = r_pend;
    w_byte  = r_byte;
    w_rs    = r_rs;
    w_data  = r_data;
    unique case (r_state)
      PWR_WAIT: begin
        if (r_cnt == INIT_C) w_state = INIT;
      end
      INIT, SETUP, ADDR: begin
        w_state = PULSE;
        w_cnt   = '0;
      end
      PULSE: begin
        if (r_cnt == EN_LAST) w_state = HOLD;
      end
      HOLD: begin
        w_state = WAIT;
        w_cnt   = '0;
      end
      WAIT: begin
        if (r_cnt == r_wlen - CW'(1)) begin
          if (r_boot) begin
            if (r_idx == 2'd3) begin
              w_state = IDLE;
              w_boot  = 1'b0;
            end else begin
              w_state = INIT;
              w_idx   = r_idx + 2'd1;
            end
          end else if (r_col == COLS_C) begin
            w_state = ADDR;
            w_rs    = 1'b0;
            w_data  = w_addr;
            w_wlen  = CMD_C;
            w_line  = ~r_line;
            w_col   = '0;
          end else begin
            w_state = IDLE;
          end
        end
      end
      IDLE: begin
        if (r_pend) begin
          // one decode cycle; bytes outside the table just fall through
          w_pend = 1'b0;
          unique case (1'b1)
            w_ff: begin
              w_state = SETUP;
              w_rs    = 1'b0;
              w_data  = 8'h01;
              w_wlen  = CLR_C;
              w_col   = '0;
              w_line  = 1'b0;
            end
            w_nl: begin
              w_state = SETUP;
              w_rs    = 1'b0;
              w_data  = w_addr;
              w_wlen  = CMD_C;
              w_col   = '0;
              w_line  = ~r_line;
            end
            w_pr: begin
              w_state = SETUP;
              w_rs    = 1'b1;
              w_data  = r_byte;
              w_wlen  = CMD_C;
              w_col   = r_col + LW'(1);
            end
            default: begin
            end
          endcase
        end else if (VALID_I) begin
          w_pend = 1'b1;
          w_byte = DATA_I;
        end
      end
      default: begin
        w_state = PWR_WAIT;
      end
    endcase
    if (w_state == INIT && r_state != INIT) begin
      w_rs   = 1'b0;
      w_data = f_init(w_idx);
      w_wlen = (w_idx == 2'd2) ? CLR_C : CMD_C;
    end
    w_en = (w_state == PULSE);
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      r_state <= PWR_WAIT;
      r_cnt   <= '0;
      r_wlen  <= '0;
      r_idx   <= 2'd0;
      r_boot  <= 1'b1;
      r_col   <= '0;
      r_line  <= 1'b0;
      r_pend  <= 1'b0;
      r_byte  <= 8'h00;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_wlen  <= w_wlen;
      r_idx   <= w_idx;
      r_boot  <= w_boot;
      r_col   <= w_col;
      r_line  <= w_line;
      r_pend  <= w_pend;
      r_byte  <= w_byte;
      r_rs    <= w_rs;
      r_data  <= w_data;
      r_en    <= w_en;
    end
  end

  assign READY_O    = (r_state == IDLE) && !r_pend;
  assign LCD_RW_O   = 1'b0;
  assign LCD_RS_O   = r_rs;
  assign LCD_EN_O   = r_en;
  assign LCD_DATA_O = r_data;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Scoreboard bench for lcd_char_ctrl: a cursor model predicts LCD writes
// and handshake timing; a bus monitor checks every EN strobe.
module tb_lcd_char_ctrl;

  localparam int EN_CYC = 2;
  localparam int CMD    = 4;
  localparam int CLR    = 10;
  localparam int COLS   = 16;
  localparam int BOOT   = 20 + 4 * (EN_CYC + 2) + 3 * CMD + CLR;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       ready;
  logic       rw;
  logic       rs;
  logic       en;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  lcd_char_ctrl #(
    .CLK_HZ (1_000_000),
    .INIT_US(20),
    .CMD_US (CMD),
    .CLR_US (CLR),
    .EN_CYC (EN_CYC),
    .COLS   (COLS)
  ) dut (
    .CLK_I     (clk),
    .RST_N_I   (rst_n),
    .DATA_I    (data_i),
    .VALID_I   (valid_i),
    .READY_O   (ready),
    .LCD_RW_O  (rw),
    .LCD_RS_O  (rs),
    .LCD_EN_O  (en),
    .LCD_DATA_O(lcd_data)
  );

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         rise;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail = 0;
  int  cyc = -1;
  bit  abort = 1'b0;
  int  m_col = 0;
  int  m_line = 0;

  always @(posedge clk) cyc <= rst_n ? cyc + 1 : -1;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", nm, got, exp, cyc);
    end
  endfunction

  function automatic void fail_now(string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cyc %0d)", nm, cyc);
  endfunction

  function automatic void push_wr(logic r, logic [7:0] d, int rise);
    wr_t w;
    w.rs = r;
    w.d = d;
    w.rise = rise;
    exp_q.push_back(w);
  endfunction

  // Cursor model: what the LCD should see for byte b accepted at cycle n
  function automatic int model(logic [7:0] b, int n);
    int dly;
    logic [7:0] a;
    a = (m_line != 0) ? 8'h80 : 8'hC0;
    if (b == 8'h0C) begin
      push_wr(1'b0, 8'h01, n + 2);
      m_col = 0;
      m_line = 0;
      dly = 1 + EN_CYC + 2 + CLR;
    end else if (b == 8'h0A) begin
      push_wr(1'b0, a, n + 2);
      m_line = 1 - m_line;
      m_col = 0;
      dly = 1 + EN_CYC + 2 + CMD;
    end else if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(1'b1, b, n + 2);
      m_col++;
      dly = 1 + EN_CYC + 2 + CMD;
      if (m_col == COLS) begin
        push_wr(1'b0, a, -1);
        m_line = 1 - m_line;
        m_col = 0;
        dly += EN_CYC + 2 + CMD;
      end
    end else begin
      dly = 1;
    end
    return dly;
  endfunction

  function automatic void push_boot();
    push_wr(1'b0, 8'h38, -1);
    push_wr(1'b0, 8'h0C, -1);
    push_wr(1'b0, 8'h01, -1);
    push_wr(1'b0, 8'h06, -1);
  endfunction

  logic       prev_en = 1'b0;
  int         width = 0;
  logic       cap_rs;
  logic [7:0] cap_d;
  wr_t        mon_e;

  always @(negedge clk) begin
    if (en === 1'b1 && prev_en !== 1'b1) begin
      width = 1;
      cap_rs = rs;
      cap_d = lcd_data;
      if (exp_q.size() == 0) begin
        fail_now($sformatf("unexpected_write rs=%0b data=%02h", rs, lcd_data));
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_rs", 32'(rs), 32'(mon_e.rs));
        chk("wr_data", 32'(lcd_data), 32'(mon_e.d));
        chk("wr_rw", 32'(rw), 32'(0));
        if (mon_e.rise >= 0) chk("en_rise_cyc", 32'(cyc), 32'(mon_e.rise));
      end
    end else if (en === 1'b1) begin
      width++;
      chk("pulse_stable", 32'({rs, lcd_data}), 32'({cap_rs, cap_d}));
    end else if (prev_en === 1'b1 && !abort) begin
      chk("en_width", 32'(width), 32'(EN_CYC));
      chk("hold_stable", 32'({rs, lcd_data}), 32'({cap_rs, cap_d}));
    end
    prev_en = en;
  end

  task automatic wait_ready(output int c, input int lim);
    c = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        c = cyc;
        break;
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    int c;
    int n;
    int dly;
    wait_ready(c, 200);
    if (c < 0) begin
      fail_now("ready_timeout_before_send");
      return;
    end
    data_i = b;
    valid_i = 1'b1;
    n = cyc + 1;
    dly = model(b, n);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    data_i = 8'($urandom);
    wait_ready(c, 200);
    chk($sformatf("ready_return_%02h", b), 32'(c), 32'(n + dly));
  endtask

  task automatic release_and_boot(input string nm);
    int c;
    push_boot();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready(c, 400);
    chk(nm, 32'(c), 32'(BOOT));
  endtask

  function automatic logic [7:0] rnd_print();
    return 8'($urandom_range(32, 126));
  endfunction

  function automatic logic [7:0] rnd_byte();
    int k;
    logic [7:0] v;
    k = $urandom_range(0, 19);
    if (k < 15) return rnd_print();
    if (k == 15) return 8'h0A;
    if (k == 16) return 8'h0C;
    v = 8'($urandom);
    while ((v >= 8'h20 && v <= 8'h7E) || v == 8'h0A || v == 8'h0C)
      v = 8'($urandom);
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", 32'(en), 32'(0));
    chk("rst_rs", 32'(rs), 32'(0));
    chk("rst_rw", 32'(rw), 32'(0));
    chk("rst_data", 32'(lcd_data), 32'(0));
    chk("rst_ready", 32'(ready), 32'(0));
    release_and_boot("boot_ready_cyc");

    send(8'h41);
    for (int i = 0; i < 15; i++) send(rnd_print());
    for (int i = 0; i < 16; i++) send(rnd_print());
    send(8'h20);
    send(8'h42);
    send(8'h7E);
    send(8'h0A);
    send(8'h0C);
    send(8'h07);
    send(8'h7F);
    send(8'h1F);
    for (int i = 0; i < 80; i++) send(rnd_byte());

    wait_ready(c, 200);
    data_i = 8'h55;
    valid_i = 1'b1;
    n = cyc + 1;
    void'(model(8'h55, n));
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    c = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (en === 1'b1) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) fail_now("en_never_rose_before_reset");
    abort = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_en", 32'(en), 32'(0));
    chk("midrst_rs", 32'(rs), 32'(0));
    chk("midrst_data", 32'(lcd_data), 32'(0));
    chk("midrst_ready", 32'(ready), 32'(0));
    m_col = 0;
    m_line = 0;
    exp_q.delete();
    release_and_boot("reboot_ready_cyc");
    abort = 1'b0;

    for (int i = 0; i < 17; i++) send(rnd_print());
    send(8'h0A);
    send(8'h43);

    repeat (30) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
